// File: rtl/tx_axis_pkg.sv
// tx_axis_pkg: AXIS widths, frame-length limits and arbiter state encoding shared by the TX path.
package tx_axis_pkg;
  localparam int TX_AXIS_DW     = 32;
  localparam int TX_AXIS_DB     = TX_AXIS_DW / 8;
  localparam int TX_MAX_PAYLOAD = 1500;
  // payload plus 14 B header and 4 B FCS, rounded up to whole beats
  localparam int TX_MAX_FRAME   = TX_MAX_PAYLOAD + 18;
  localparam int TX_MAX_BEATS   = (TX_MAX_FRAME + TX_AXIS_DB - 1) / TX_AXIS_DB;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker with optional fixed priority for requester 0.
module rr_arbiter
  import tx_axis_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          prio_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  logic          found;
  logic [IW-1:0] c;
  always_comb begin
    idx_o = '0;
    found = 1'b0;
    c     = '0;
    for (int i = 1; i <= N; i++) begin
      c = IW'((int'(ptr_i) + i) % N);
      if (!found && req_i[c]) begin
        found = 1'b1;
        idx_o = c;
      end
    end
    if (prio_i && req_i[0]) idx_o = '0;
    gnt_o = (|req_i) ? N'(1) << idx_o : '0;
  end
endmodule

// File: rtl/tx_axis_frame_arbiter.sv
// tx_axis_frame_arbiter: frame-atomic AXIS mux in front of the TX MAC, with runaway-frame
// truncation so a stuck source cannot hold the MAC forever.
module tx_axis_frame_arbiter
  import tx_axis_pkg::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int AXIS_DATA_WIDTH = TX_AXIS_DW,
  parameter int AXIS_DATA_BYTES = AXIS_DATA_WIDTH / 8,
  parameter int MAX_BEATS       = TX_MAX_BEATS,
  parameter bit PRIO_PORT0      = 1'b0
) (
  input  logic                                 tx_clk,
  input  logic                                 tx_rst,
  input  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_PORTS*AXIS_DATA_BYTES-1:0] s_tkeep,
  input  logic [NUM_PORTS-1:0]                 s_tvalid,
  input  logic [NUM_PORTS-1:0]                 s_tlast,
  output logic [NUM_PORTS-1:0]                 s_tready,
  output logic [AXIS_DATA_WIDTH-1:0]           m_tdata,
  output logic [AXIS_DATA_BYTES-1:0]           m_tkeep,
  output logic                                 m_tvalid,
  output logic                                 m_tlast,
  input  logic                                 m_tready,
  output logic [NUM_PORTS-1:0]                 grant,
  output logic                                 busy,
  output logic                                 trunc_err
);
  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = $clog2(MAX_BEATS + 1);
  arb_state_e                 state_q, state_d;
  logic [NUM_PORTS-1:0]       grant_q, grant_d, win_oh;
  logic [IW-1:0]              idx_q, idx_d, rr_ptr_q, rr_ptr_d, win_idx;
  logic [CW-1:0]              beat_cnt_q, beat_cnt_d;
  logic                       trunc_q, trunc_d, hs, at_max, pass;
  logic [AXIS_DATA_WIDTH-1:0] dat [NUM_PORTS];
  logic [AXIS_DATA_BYTES-1:0] kep [NUM_PORTS];
  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_unpack
    assign dat[k] = s_tdata[k*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
    assign kep[k] = s_tkeep[k*AXIS_DATA_BYTES +: AXIS_DATA_BYTES];
  end
  rr_arbiter #(.N(NUM_PORTS)) u_pick (
    .req_i  (s_tvalid),
    .ptr_i  (rr_ptr_q),
    .prio_i (PRIO_PORT0),
    .gnt_o  (win_oh),
    .idx_o  (win_idx)
  );
  assign pass   = state_q == ST_PASS;
  assign at_max = beat_cnt_q == CW'(MAX_BEATS - 1);
  assign hs     = pass && s_tvalid[idx_q] && m_tready;
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    idx_d      = idx_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    trunc_d    = 1'b0;
    if (state_q == ST_IDLE && |s_tvalid) begin
      state_d  = ST_PASS;
      grant_d  = win_oh;
      idx_d    = win_idx;
      rr_ptr_d = win_idx;
    end
    if (hs) begin
      beat_cnt_d = beat_cnt_q + CW'(1);
      state_d    = s_tlast[idx_q] ? ST_IDLE : at_max ? ST_DRAIN : ST_PASS;
      trunc_d    = !s_tlast[idx_q] && at_max;
    end
    if (state_q == ST_DRAIN && s_tvalid[idx_q] && s_tlast[idx_q]) state_d = ST_IDLE;
    // leaving a frame always releases the grant and rearms the length limit
    if (state_d == ST_IDLE) begin
      grant_d    = '0;
      beat_cnt_d = '0;
    end
  end
  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      idx_q      <= '0;
      rr_ptr_q   <= IW'(NUM_PORTS - 1);
      beat_cnt_q <= '0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      idx_q      <= idx_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      trunc_q    <= trunc_d;
    end
  end
  // m_tvalid never depends on m_tready: the MAC ready is registered on its side
  assign m_tvalid  = pass && s_tvalid[idx_q];
  assign m_tlast   = pass && (s_tlast[idx_q] || at_max);
  assign m_tdata   = pass ? dat[idx_q] : '0;
  assign m_tkeep   = pass ? kep[idx_q] : '0;
  assign s_tready  = pass ? (m_tready ? grant_q : '0) : (state_q == ST_DRAIN ? grant_q : '0);
  assign grant     = grant_q;
  assign busy      = state_q != ST_IDLE;
  assign trunc_err = trunc_q;
endmodule

// File: tb/tb_tx_axis_frame_arbiter.sv
// tb_tx_axis_frame_arbiter: random AXIS sources on two arbiter instances (round-robin and
// port-0 priority), each compared cycle by cycle against a frame-level reference model.
module tb_tx_axis_frame_arbiter;
  localparam int N  = 2;
  localparam int W  = 32;
  localparam int B  = 4;
  localparam int MB = 8;
  logic clk  = 1'b0;
  logic rst  = 1'b1;
  int   mode = 0;
  int   n_vec = 0;
  int   n_err = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  for (genvar d = 0; d < 2; d++) begin : g_i
    logic [N*W-1:0] s_tdata  = '0;
    logic [N*B-1:0] s_tkeep  = '0;
    logic [N-1:0]   s_tvalid = '0;
    logic [N-1:0]   s_tlast  = '0;
    logic [N-1:0]   s_tready;
    logic [W-1:0]   m_tdata;
    logic [B-1:0]   m_tkeep;
    logic           m_tvalid, m_tlast;
    logic           m_tready = 1'b0;
    logic [N-1:0]   grant;
    logic           busy, trunc_err;

    tx_axis_frame_arbiter #(
      .NUM_PORTS(N), .AXIS_DATA_WIDTH(W), .AXIS_DATA_BYTES(B),
      .MAX_BEATS(MB), .PRIO_PORT0(d == 1)
    ) u_dut (
      .tx_clk(clk), .tx_rst(rst),
      .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
      .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
      .m_tready(m_tready),
      .grant(grant), .busy(busy), .trunc_err(trunc_err)
    );

    int       len [N];
    int       pos [N];
    logic [7:0] fid [N];
    bit       hs  [N];
    int       owner = -1;
    int       beats = 0;
    int       last  = N - 1;
    bit       drain = 1'b0;
    bit       tpend = 1'b0;
    bit       tn, pas;
    int       w, c;
    logic [N-1:0] e_gnt, e_rdy;
    logic [W-1:0] e_dat;
    logic [B-1:0] e_kep;
    logic         e_vld, e_lst;

    initial begin
      for (int p = 0; p < N; p++) begin
        len[p] = $urandom_range(1, 12);
        pos[p] = 0;
        fid[p] = 8'(p * 64);
        hs[p]  = 1'b0;
      end
      forever begin
        @(negedge clk);
        for (int p = 0; p < N; p++) begin
          if (hs[p]) begin
            pos[p]++;
            if (pos[p] == len[p]) begin
              pos[p] = 0;
              len[p] = $urandom_range(1, 12);
              fid[p]++;
            end
          end
          if (!(s_tvalid[p] && !hs[p]))
            s_tvalid[p] = (mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
          s_tdata[p*W +: W] = {4'(d), 4'(p), fid[p], 16'(pos[p])};
          s_tlast[p]        = pos[p] == len[p] - 1;
          s_tkeep[p*B +: B] = s_tlast[p] ? (4'hF >> fid[p][1:0]) : 4'hF;
        end
        m_tready = (mode == 1) ? 1'b1 : (mode == 2) ? ($urandom_range(0, 3) == 0)
                                                    : ($urandom_range(0, 3) != 0);
        #1;
        pas   = owner >= 0 && !drain;
        e_gnt = (owner < 0) ? '0 : N'(1) << owner;
        e_rdy = (owner < 0) ? '0 : (drain || m_tready) ? N'(1) << owner : '0;
        e_vld = pas ? s_tvalid[owner] : 1'b0;
        e_lst = pas ? (s_tlast[owner] || beats == MB - 1) : 1'b0;
        e_dat = pas ? s_tdata[owner*W +: W] : '0;
        e_kep = pas ? s_tkeep[owner*B +: B] : '0;
        check($sformatf("d%0d.grant", d),     64'(grant),     64'(e_gnt));
        check($sformatf("d%0d.busy", d),      64'(busy),      64'(owner >= 0));
        check($sformatf("d%0d.trunc_err", d), 64'(trunc_err), 64'(tpend));
        check($sformatf("d%0d.s_tready", d),  64'(s_tready),  64'(e_rdy));
        check($sformatf("d%0d.m_tvalid", d),  64'(m_tvalid),  64'(e_vld));
        check($sformatf("d%0d.m_tlast", d),   64'(m_tlast),   64'(e_lst));
        check($sformatf("d%0d.m_tdata", d),   64'(m_tdata),   64'(e_dat));
        check($sformatf("d%0d.m_tkeep", d),   64'(m_tkeep),   64'(e_kep));
        for (int p = 0; p < N; p++) hs[p] = s_tvalid[p] && s_tready[p];
        if (rst) begin
          owner = -1; beats = 0; last = N - 1; drain = 1'b0; tpend = 1'b0;
        end else begin
          tn = 1'b0;
          if (owner < 0) begin
            if (|s_tvalid) begin
              w = -1;
              if (d == 1 && s_tvalid[0]) w = 0;
              else for (int k = 1; k <= N; k++) begin
                c = (last + k) % N;
                if (w < 0 && s_tvalid[c]) w = c;
              end
              owner = w; last = w; beats = 0;
            end
          end else if (!drain) begin
            if (s_tvalid[owner] && m_tready) begin
              if (s_tlast[owner]) owner = -1;
              else if (beats == MB - 1) begin drain = 1'b1; tn = 1'b1; end
              else beats++;
            end
          end else if (s_tvalid[owner] && s_tlast[owner]) begin
            owner = -1; drain = 1'b0;
          end
          tpend = tn;
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    for (int ph = 0; ph < 3; ph++) begin
      mode = ph;
      repeat (700) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
      repeat (300) @(posedge clk);
    end
    #2 $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
